hazard_sched: RTL and testbench
===============================

# hazard_sched

Pipeline hazard and stall/flush scheduler for the five-stage MIPS core. It watches the instructions in D, E and M and detects load-use hazards and HI/LO conflicts with the multi-cycle multiply/divide unit. It also accepts exception/redirect flush requests. From these it produces the stall and flush controls that freeze the PC and F/D register and insert bubbles into the D/E and E/M pipeline registers. It also tracks multiply/divide occupancy with an internal state machine and counter, and keeps a stall-cycle performance counter.

## Interface
- MULT_LAT, 5: cycles the multiplier stays busy after issue
- DIV_LAT, 10: cycles the divider stays busy after issue
- CNT_W, 32: width of the stall-cycle counter

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- rs_d, rt_d  in  5 each  source register numbers of the instruction in D
- use_rs_d, use_rt_d  in  1 each  D instruction needs rs/rt in D or E (operand required before M)
- regwrite_e  in  1  E instruction writes the GPR file
- memtoreg_e  in  1  E instruction is a load
- dst_e  in  5  destination register of the E instruction
- md_use_d  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
- md_start_e  in  1  mult/div instruction in E issues this cycle
- md_is_div_e  in  1  qualifies md_start_e: 1 = div/divu, 0 = mult/multu
- flush_req  in  1  exception/eret redirect detected in M
- stall_f  out  1  hold PC
- stall_d  out  1  hold F/D register
- flush_d  out  1  clear F/D register
- flush_e  out  1  load bubble into D/E register
- flush_m  out  1  load bubble into E/M register
- md_busy  out  1  multiply/divide unit occupied
- stall_cycles  out  CNT_W  count of cycles with stall_d = 1

## Operation
- Load-use hazard: lu = memtoreg_e & regwrite_e & (dst_e != 0) & ((use_rs_d & rs_d == dst_e) | (use_rt_d & rt_d == dst_e)).
- MD hazard: md = md_use_d & md_busy.
- md_busy = (state != IDLE) | (md_start_e & ~flush_req).
- stall = (lu | md) & ~flush_req.
- stall_f = stall_d = flush_e = stall.
- flush_req = 1 forces flush_d = flush_e = flush_m = 1 and stall_f = stall_d = 0. Redirect wins over any stall.
- State machine states:
  - IDLE, MUL, DIV.
  - IDLE --(md_start_e & ~flush_req)--> MUL or DIV, chosen by md_is_div_e. The counter loads MULT_LAT or DIV_LAT.
  - In MUL/DIV the counter decrements each cycle. When the counter is 1, the next state is IDLE and the counter becomes 0.
- md_start_e while the state is not IDLE is a protocol violation (D would have stalled). It is ignored: no reload, no state change. The bench asserts that it never occurs.
- md_start_e with flush_req = 1 is ignored, because the E instruction is being squashed.
- flush_req does not abort an operation already in MUL/DIV. The unit keeps counting.
- stall_cycles increments by 1 on each cycle with stall_d = 1. It wraps modulo 2^CNT_W.
- Register 0 never causes a load-use hazard.

## Timing
- All outputs except md_busy's state term and stall_cycles are combinational from the current inputs and state. They are valid in the same cycle so that the pipeline registers sample them at the next edge.
- A start accepted in cycle t gives md_busy = 1 in cycles t through t+LAT (LAT+1 cycles). md_busy = 0 in cycle t+LAT+1.
- A load in E with a dependent instruction in D gives exactly one stall cycle, after which the load has moved to M.
- Reset asserted mid-operation: state goes to IDLE, the counter to 0 and stall_cycles to 0 immediately, without waiting for a clock edge.
- Reset values: md_busy = 0, stall_cycles = 0. stall_f, stall_d and the flush_* outputs are 0 whenever the inputs are 0.

## Structure
- Shared package `hazard_pkg`:
  - state encoding typedef (IDLE/MUL/DIV);
  - default latency constants MULT_LAT_DEF and DIV_LAT_DEF.
- One natural sub-module, `md_busy_tracker`: the state machine plus the latency counter. Its ports are md_start, md_is_div, cancel and md_busy.
- The hazard comparators and output muxing stay in the top module.

## Test plan
- Load-use: memtoreg_e = 1, regwrite_e = 1, dst_e = 8, rs_d = 8, use_rs_d = 1 for one cycle -> stall_f = stall_d = flush_e = 1 in that cycle only; stall_cycles goes 0 -> 1.
- Load to r0: as above with dst_e = 0, rs_d = 0 -> no stall.
- Multiply: md_start_e = 1, md_is_div_e = 0 in cycle 0, with md_use_d = 1 from cycle 1 -> md_busy = 1 in cycles 0–5, stall_d = 1 in cycles 1–5, both 0 in cycle 6. Repeat as a divide -> stall through cycle 10.
- Flush priority: lu = 1 together with flush_req = 1 -> stall_d = 0, flush_d = flush_e = flush_m = 1, stall_cycles unchanged.
- Squashed start: md_start_e = 1 with flush_req = 1 -> md_busy = 0 in the next cycle; the state stays IDLE.
- Reset mid-divide: reset driven low in cycle 4 of a divide -> md_busy = 0 and stall_cycles = 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/hazard_sched_pkg.sv
// Shared types and default latencies for the hazard/stall scheduler and its
// multiply/divide occupancy tracker.
package hazard_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDiv
    } md_state_e;

    localparam int unsigned MULT_LAT_DEF = 5;
    localparam int unsigned DIV_LAT_DEF  = 10;

endpackage

// File: rtl/hazard_sched_if.sv
// Pipeline-side bundle of hazard inputs and stall/flush controls.
// The scheduler takes the slave modport; the pipeline drives the master modport.
interface hazard_sched_if #(
    parameter int unsigned CNT_W = 32
);

    logic [4:0]       rs_d;
    logic [4:0]       rt_d;
    logic             use_rs_d;
    logic             use_rt_d;
    logic             regwrite_e;
    logic             memtoreg_e;
    logic [4:0]       dst_e;
    logic             md_use_d;
    logic             md_start_e;
    logic             md_is_div_e;
    logic             flush_req;
    logic             stall_f;
    logic             stall_d;
    logic             flush_d;
    logic             flush_e;
    logic             flush_m;
    logic             md_busy;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output rs_d, rt_d, use_rs_d, use_rt_d, regwrite_e, memtoreg_e, dst_e,
               md_use_d, md_start_e, md_is_div_e, flush_req,
        input  stall_f, stall_d, flush_d, flush_e, flush_m, md_busy, stall_cycles
    );

    modport slave (
        input  rs_d, rt_d, use_rs_d, use_rt_d, regwrite_e, memtoreg_e, dst_e,
               md_use_d, md_start_e, md_is_div_e, flush_req,
        output stall_f, stall_d, flush_d, flush_e, flush_m, md_busy, stall_cycles
    );

endinterface

// File: rtl/hazard_sched_md_busy_tracker.sv
// Multiply/divide occupancy: IDLE/MUL/DIV state plus a latency down-counter.
// md_busy covers the issue cycle combinationally and the LAT following cycles.
module md_busy_tracker
    import hazard_pkg::*;
#(
    parameter int unsigned MULT_LAT = MULT_LAT_DEF,
    parameter int unsigned DIV_LAT  = DIV_LAT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic md_start,
    input  logic md_is_div,
    input  logic cancel,
    output logic md_busy
);

    localparam int unsigned MaxLat = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
    localparam int unsigned CntW   = $clog2(MaxLat + 1);

    md_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            accept;

    // Starts outside IDLE are illegal and dropped; squashed starts never issue.
    assign accept = md_start & ~cancel;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = md_is_div ? StDiv : StMul;
                    cnt_d   = md_is_div ? CntW'(DIV_LAT) : CntW'(MULT_LAT);
                end
            end
            StMul, StDiv: begin
                if (cnt_q == CntW'(1)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign md_busy = (state_q != StIdle) | (state_q == StIdle & accept);

endmodule

// File: rtl/hazard_sched.sv
// Stall/flush scheduler: load-use and HI/LO hazard detection, redirect priority,
// and a wrapping count of stalled cycles.
module hazard_sched
    import hazard_pkg::*;
#(
    parameter int unsigned MULT_LAT = MULT_LAT_DEF,
    parameter int unsigned DIV_LAT  = DIV_LAT_DEF,
    parameter int unsigned CNT_W    = 32
) (
    input  logic          clk,
    input  logic          reset,
    hazard_sched_if.slave bus
);

    logic             lu;
    logic             md;
    logic             md_busy;
    logic             stall;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    md_busy_tracker #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_md_busy_tracker (
        .clk       (clk),
        .reset     (reset),
        .md_start  (bus.md_start_e),
        .md_is_div (bus.md_is_div_e),
        .cancel    (bus.flush_req),
        .md_busy   (md_busy)
    );

    // r0 is hardwired zero, so a load targeting it can never feed a consumer.
    assign lu = bus.memtoreg_e & bus.regwrite_e & (bus.dst_e != 5'd0) &
                ((bus.use_rs_d & (bus.rs_d == bus.dst_e)) |
                 (bus.use_rt_d & (bus.rt_d == bus.dst_e)));

    assign md    = bus.md_use_d & md_busy;
    assign stall = (lu | md) & ~bus.flush_req;

    assign bus.stall_f      = stall;
    assign bus.stall_d      = stall;
    assign bus.flush_d      = bus.flush_req;
    assign bus.flush_e      = stall | bus.flush_req;
    assign bus.flush_m      = bus.flush_req;
    assign bus.md_busy      = md_busy;
    assign bus.stall_cycles = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (stall) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_sched.sv
// Self-checking bench for hazard_sched: directed scenarios followed by random
// traffic, all compared against a cycle-level reference model.
module tb_hazard_sched;

    localparam int unsigned MulLat = 5;
    localparam int unsigned DivLat = 10;

    logic clk;
    logic reset;

    hazard_sched_if #(.CNT_W(32)) bus ();

    hazard_sched #(
        .MULT_LAT (MulLat),
        .DIV_LAT  (DivLat),
        .CNT_W    (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int unsigned n_vec;
    int unsigned n_err;
    int unsigned busy_left;  // future cycles the MD unit remains occupied
    int unsigned m_cnt;      // expected stall count, wraps like a 32-bit counter

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_in();
        bus.rs_d        = 5'd0;
        bus.rt_d        = 5'd0;
        bus.use_rs_d    = 1'b0;
        bus.use_rt_d    = 1'b0;
        bus.regwrite_e  = 1'b0;
        bus.memtoreg_e  = 1'b0;
        bus.dst_e       = 5'd0;
        bus.md_use_d    = 1'b0;
        bus.md_start_e  = 1'b0;
        bus.md_is_div_e = 1'b0;
        bus.flush_req   = 1'b0;
    endtask

    task automatic set_load(input logic [4:0] dst);
        bus.memtoreg_e = 1'b1;
        bus.regwrite_e = 1'b1;
        bus.dst_e      = dst;
    endtask

    // Check one cycle against the model, then advance the model across the edge.
    task automatic step(input string tag);
        logic lu, busy, stall, fl;
        @(negedge clk);
        assert (!(bus.md_start_e && busy_left != 0))
            else $error("md_start_e driven while the MD unit is occupied");
        fl    = bus.flush_req;
        lu    = bus.memtoreg_e && bus.regwrite_e && bus.dst_e != 5'd0 &&
                ((bus.use_rs_d && bus.rs_d == bus.dst_e) ||
                 (bus.use_rt_d && bus.rt_d == bus.dst_e));
        busy  = (busy_left != 0) || (bus.md_start_e && !fl);
        stall = (lu || (bus.md_use_d && busy)) && !fl;
        chk({tag, "/ctl{sf,sd,fd,fe,fm,busy}"},
            64'({bus.stall_f, bus.stall_d, bus.flush_d, bus.flush_e, bus.flush_m, bus.md_busy}),
            64'({stall, stall, fl, stall | fl, fl, busy}));
        chk({tag, "/stall_cycles"}, 64'(bus.stall_cycles), 64'(m_cnt));
        @(posedge clk);
        if (stall) m_cnt++;
        if (bus.md_start_e && !fl && busy_left == 0) begin
            busy_left = bus.md_is_div_e ? DivLat : MulLat;
        end else if (busy_left != 0) begin
            busy_left--;
        end
        #1;
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        busy_left = 0;
        m_cnt     = 0;
        reset     = 1'b0;
        clear_in();

        #2;
        chk("reset/ctl", 64'({bus.stall_f, bus.stall_d, bus.flush_d, bus.flush_e, bus.flush_m,
                              bus.md_busy}), 64'(0));
        chk("reset/stall_cycles", 64'(bus.stall_cycles), 64'(0));
        #10 reset = 1'b1;
        @(posedge clk);
        #1;

        // Load-use on rs, then the load has moved on.
        set_load(5'd8); bus.rs_d = 5'd8; bus.use_rs_d = 1'b1;
        step("lu_rs");
        clear_in();
        step("lu_after");
        // Load-use on rt; matching reg but operand unused; load to r0.
        set_load(5'd9); bus.rt_d = 5'd9; bus.use_rt_d = 1'b1;
        step("lu_rt");
        bus.use_rt_d = 1'b0;
        step("lu_unused");
        clear_in();
        set_load(5'd0); bus.rs_d = 5'd0; bus.use_rs_d = 1'b1;
        step("lu_r0");

        // Multiply then divide, consumer waiting from cycle 1.
        clear_in();
        bus.md_start_e = 1'b1;
        step("mul_c0");
        bus.md_start_e = 1'b0; bus.md_use_d = 1'b1;
        for (int i = 1; i <= 6; i++) step($sformatf("mul_c%0d", i));
        clear_in();
        bus.md_start_e = 1'b1; bus.md_is_div_e = 1'b1;
        step("div_c0");
        bus.md_start_e = 1'b0; bus.md_use_d = 1'b1;
        for (int i = 1; i <= 11; i++) step($sformatf("div_c%0d", i));

        // Redirect beats a load-use stall.
        clear_in();
        set_load(5'd3); bus.rs_d = 5'd3; bus.use_rs_d = 1'b1; bus.flush_req = 1'b1;
        step("flush_pri");

        // Squashed start never occupies the unit.
        clear_in();
        bus.md_start_e = 1'b1; bus.flush_req = 1'b1;
        step("squash");
        clear_in();
        bus.md_use_d = 1'b1;
        step("squash_next");

        // Asynchronous reset in cycle 4 of a divide.
        clear_in();
        bus.md_start_e = 1'b1; bus.md_is_div_e = 1'b1;
        step("rdiv_c0");
        bus.md_start_e = 1'b0; bus.md_use_d = 1'b1;
        for (int i = 1; i <= 3; i++) step($sformatf("rdiv_c%0d", i));
        #2 reset = 1'b0;
        #1;
        chk("rst_mid/md_busy", 64'(bus.md_busy), 64'(0));
        chk("rst_mid/stall_d", 64'(bus.stall_d), 64'(0));
        chk("rst_mid/stall_cycles", 64'(bus.stall_cycles), 64'(0));
        busy_left = 0;
        m_cnt     = 0;
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        clear_in();
        step("post_rst");

        // Random traffic over a small register set so hazards are frequent.
        repeat (400) begin
            clear_in();
            bus.rs_d        = 5'($urandom_range(0, 3));
            bus.rt_d        = 5'($urandom_range(0, 3));
            bus.dst_e       = 5'($urandom_range(0, 3));
            bus.use_rs_d    = 1'($urandom_range(0, 1));
            bus.use_rt_d    = 1'($urandom_range(0, 1));
            bus.regwrite_e  = 1'($urandom_range(0, 1));
            bus.memtoreg_e  = 1'($urandom_range(0, 1));
            bus.md_use_d    = 1'($urandom_range(0, 1));
            bus.md_is_div_e = 1'($urandom_range(0, 1));
            bus.flush_req   = ($urandom_range(0, 7) == 0);
            bus.md_start_e  = (busy_left == 0) && ($urandom_range(0, 3) == 0);
            step("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
